// File: rtl/kvs_req_mux.sv
// Request multiplexer between NUM_CH per-port eth_top instances and one db_top lookup port.
// Per-channel request FIFOs, round-robin issue under an outstanding limit, in-order response routing.
module kvs_req_mux #(
   parameter int NUM_CH     = 4,
   parameter int KEY_SIZE   = 96,
   parameter int FLAG_SIZE  = 4,
   parameter int FIFO_DEPTH = 8,
   parameter int MAX_OUT    = 16
) (
   input  logic                          clk,
   input  logic                          sys_rst_n,
   input  logic [NUM_CH-1:0]             ch_in_valid,
   input  logic [NUM_CH*KEY_SIZE-1:0]    ch_in_key,
   input  logic [NUM_CH*FLAG_SIZE-1:0]   ch_in_flag,
   output logic [NUM_CH-1:0]             ch_in_ready,
   output logic [NUM_CH-1:0]             ch_out_valid,
   output logic [FLAG_SIZE-1:0]          ch_out_flag,
   output logic                          db_in_valid,
   output logic [KEY_SIZE-1:0]           db_in_key,
   output logic [FLAG_SIZE-1:0]          db_in_flag,
   input  logic                          db_out_valid,
   input  logic [FLAG_SIZE-1:0]          db_out_flag,
   output logic [NUM_CH*16-1:0]          drop_cnt,
   output logic                          err_spurious
);

   localparam int CH_W = $clog2(NUM_CH);
   localparam int PW   = $clog2(FIFO_DEPTH);
   localparam int OW   = $clog2(MAX_OUT) + 1;
   localparam int TW   = $clog2(MAX_OUT);
   localparam int EW   = KEY_SIZE + FLAG_SIZE;

   logic [EW-1:0]     fifo_mem [NUM_CH][FIFO_DEPTH];
   logic [PW:0]       wr_ptr   [NUM_CH];
   logic [PW:0]       rd_ptr   [NUM_CH];
   logic [PW:0]       wr_nxt   [NUM_CH];
   logic [PW:0]       rd_nxt   [NUM_CH];
   logic [15:0]       drops    [NUM_CH];
   logic [CH_W-1:0]   tag_mem  [MAX_OUT];
   logic [TW-1:0]     tag_wr;
   logic [TW-1:0]     tag_rd;
   logic [NUM_CH-1:0] empty;
   logic [NUM_CH-1:0] full;
   logic [NUM_CH-1:0] push;
   logic [NUM_CH-1:0] pop;
   logic [NUM_CH-1:0] ready_nxt;
   logic [CH_W-1:0]   rr;
   logic [CH_W-1:0]   cand;
   logic [CH_W-1:0]   grant_idx;
   logic              grant_any;
   logic              issue;
   logic              resp;
   logic [OW-1:0]     outstanding;

   function automatic logic is_full(input logic [PW:0] w, input logic [PW:0] r);
      return (w[PW] != r[PW]) && (w[PW-1:0] == r[PW-1:0]);
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

   always_comb begin
      empty = '0;
      full  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         empty[i] = (wr_ptr[i] == rd_ptr[i]);
         full[i]  = is_full(wr_ptr[i], rd_ptr[i]);
      end
   end

   // Round-robin search starting just after the last granted channel.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int k = 1; k <= NUM_CH; k++) begin
         cand = CH_W'((int'(rr) + k) % NUM_CH);
         if (!grant_any && !empty[cand]) begin
            grant_any = 1'b1;
            grant_idx = cand;
         end
      end
   end

   // Issue gate looks at the count before this cycle's response is retired.
   assign issue = grant_any && (outstanding < OW'(MAX_OUT));
   assign resp  = db_out_valid && (outstanding != '0);
   assign pop   = issue ? (NUM_CH'(1) << grant_idx) : '0;

   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   always_comb begin
      push      = '0;
      ready_nxt = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         push[i]      = ch_in_valid[i] && (!full[i] || pop[i]);
         wr_nxt[i]    = wr_ptr[i] + {{PW{1'b0}}, push[i]};
         rd_nxt[i]    = rd_ptr[i] + {{PW{1'b0}}, pop[i]};
         ready_nxt[i] = !is_full(wr_nxt[i], rd_nxt[i]);
      end
   end

   always_comb begin
      drop_cnt = '0;
      for (int i = 0; i < NUM_CH; i++) drop_cnt[i*16 +: 16] = drops[i];
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (push[i])
            fifo_mem[i][wr_ptr[i][PW-1:0]] <= {ch_in_key[i*KEY_SIZE +: KEY_SIZE],
                                               ch_in_flag[i*FLAG_SIZE +: FLAG_SIZE]};
      end
      if (issue) tag_mem[tag_wr] <= grant_idx;
   end

   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
            drops[i]  <= '0;
         end
         ch_in_ready  <= '1;
         rr           <= CH_W'(NUM_CH - 1);
         outstanding  <= '0;
         tag_wr       <= '0;
         tag_rd       <= '0;
         db_in_valid  <= 1'b0;
         db_in_key    <= '0;
         db_in_flag   <= '0;
         ch_out_valid <= '0;
         ch_out_flag  <= '0;
         err_spurious <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            wr_ptr[i] <= wr_nxt[i];
            rd_ptr[i] <= rd_nxt[i];
            if (ch_in_valid[i] && !push[i]) drops[i] <= sat_inc(drops[i]);
         end
         ch_in_ready <= ready_nxt;

         db_in_valid <= issue;
         if (issue) begin
            rr                      <= grant_idx;
            {db_in_key, db_in_flag} <= fifo_mem[grant_idx][rd_ptr[grant_idx][PW-1:0]];
            tag_wr                  <= tag_wr + TW'(1);
         end

         if (resp) begin
            tag_rd       <= tag_rd + TW'(1);
            ch_out_valid <= NUM_CH'(1) << tag_mem[tag_rd];
            ch_out_flag  <= db_out_flag;
         end else begin
            ch_out_valid <= '0;
         end

         if (db_out_valid && (outstanding == '0)) err_spurious <= 1'b1;

         case ({issue, resp})
            2'b10:   outstanding <= outstanding + OW'(1);
            2'b01:   outstanding <= outstanding - OW'(1);
            default: outstanding <= outstanding;
         endcase
      end
   end

endmodule

// File: tb/tb_kvs_req_mux.sv
// Directed bench for kvs_req_mux: single request, fair rotation, outstanding stall and drops,
// gate at MAX_OUT, spurious responses and asynchronous reset mid-burst.
module tb_kvs_req_mux;

   localparam int NUM_CH = 4;
   localparam int KEY_SIZE = 96;
   localparam int FLAG_SIZE = 4;

   logic                        clk = 1'b0;
   logic                        sys_rst_n = 1'b0;
   logic [NUM_CH-1:0]           ch_in_valid = '0;
   logic [NUM_CH*KEY_SIZE-1:0]  ch_in_key = '0;
   logic [NUM_CH*FLAG_SIZE-1:0] ch_in_flag = '0;
   logic [NUM_CH-1:0]           ch_in_ready;
   logic [NUM_CH-1:0]           ch_out_valid;
   logic [FLAG_SIZE-1:0]        ch_out_flag;
   logic                        db_in_valid;
   logic [KEY_SIZE-1:0]         db_in_key;
   logic [FLAG_SIZE-1:0]        db_in_flag;
   logic                        db_out_valid = 1'b0;
   logic [FLAG_SIZE-1:0]        db_out_flag = '0;
   logic [NUM_CH*16-1:0]        drop_cnt;
   logic                        err_spurious;

   int n_chk = 0;
   int n_fail = 0;

   kvs_req_mux #(
      .NUM_CH(NUM_CH), .KEY_SIZE(KEY_SIZE), .FLAG_SIZE(FLAG_SIZE), .FIFO_DEPTH(8), .MAX_OUT(16)
   ) dut (
      .clk(clk), .sys_rst_n(sys_rst_n),
      .ch_in_valid(ch_in_valid), .ch_in_key(ch_in_key), .ch_in_flag(ch_in_flag),
      .ch_in_ready(ch_in_ready), .ch_out_valid(ch_out_valid), .ch_out_flag(ch_out_flag),
      .db_in_valid(db_in_valid), .db_in_key(db_in_key), .db_in_flag(db_in_flag),
      .db_out_valid(db_out_valid), .db_out_flag(db_out_flag),
      .drop_cnt(drop_cnt), .err_spurious(err_spurious)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int ch, input logic [95:0] key, input logic [3:0] flag);
      ch_in_key[ch*KEY_SIZE +: KEY_SIZE]    = key;
      ch_in_flag[ch*FLAG_SIZE +: FLAG_SIZE] = flag;
   endtask

   task automatic do_reset();
      sys_rst_n    = 1'b0;
      ch_in_valid  = '0;
      db_out_valid = 1'b0;
      db_out_flag  = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      sys_rst_n = 1'b1;
      step();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int sent[NUM_CH];
      int got[NUM_CH];
      int n_iss;
      int n_resp;
      int ex;
      logic dv[3];
      logic [3:0] dc[3];
      logic [95:0] first_key;
      logic [95:0] last_key;
      int q[$];

      // Test 1: reset values and a single request/response
      do_reset();
      chk("rst_db_in_valid", db_in_valid, 0);
      chk("rst_ch_out_valid", ch_out_valid, 0);
      chk("rst_ch_in_ready", ch_in_ready, 4'hF);
      chk("rst_drop_cnt", drop_cnt, 0);
      chk("rst_err", err_spurious, 0);
      chk("rst_db_in_key", db_in_key, 0);
      ch_in_valid = 4'b0001;
      set_req(0, 96'h1, 4'h3);
      step();
      ch_in_valid = '0;
      chk("t1_not_yet", db_in_valid, 0);
      step();
      chk("t1_valid", db_in_valid, 1);
      chk("t1_key", db_in_key, 96'h1);
      chk("t1_flag", db_in_flag, 4'h3);
      step();
      chk("t1_single", db_in_valid, 0);
      db_out_valid = 1'b1;
      db_out_flag  = 4'h5;
      step();
      db_out_valid = 1'b0;
      chk("t1_route", ch_out_valid, 4'b0001);
      chk("t1_oflag", ch_out_flag, 4'h5);
      step();
      chk("t1_pulse", ch_out_valid, 0);
      chk("t1_oflag_hold", ch_out_flag, 4'h5);

      // Test 2: four channels, 8 requests each, db answers 3 cycles after issue
      do_reset();
      n_iss = 0;
      n_resp = 0;
      for (int i = 0; i < 3; i++) begin
         dv[i] = 1'b0;
         dc[i] = '0;
      end
      for (int i = 0; i < NUM_CH; i++) begin
         sent[i] = 0;
         got[i] = 0;
      end
      for (int cyc = 0; cyc < 300 && n_resp < 32; cyc++) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (sent[i] < 8 && ch_in_ready[i]) begin
               ch_in_valid[i] = 1'b1;
               set_req(i, {80'h0, 8'(i), 8'(sent[i])}, 4'(i));
               sent[i]++;
            end else begin
               ch_in_valid[i] = 1'b0;
            end
         end
         db_out_valid = dv[2];
         db_out_flag  = dc[2];
         step();
         dv[2] = dv[1]; dc[2] = dc[1];
         dv[1] = dv[0]; dc[1] = dc[0];
         dv[0] = 1'b0;
         if (db_in_valid) begin
            chk("t2_grant", db_in_key[15:8], n_iss % 4);
            chk("t2_iflag", db_in_flag, n_iss % 4);
            q.push_back(n_iss % 4);
            dv[0] = 1'b1;
            dc[0] = db_in_flag;
            n_iss++;
         end
         if (ch_out_valid != '0) begin
            if (q.size() == 0) begin
               chk("t2_unexpected_resp", ch_out_valid, 0);
            end else begin
               ex = q.pop_front();
               chk("t2_route", ch_out_valid, 1 << ex);
               chk("t2_oflag", ch_out_flag, ex);
               got[ex]++;
            end
            n_resp++;
         end
      end
      ch_in_valid  = '0;
      db_out_valid = 1'b0;
      chk("t2_issued", n_iss, 32);
      chk("t2_responses", n_resp, 32);
      for (int i = 0; i < NUM_CH; i++) chk($sformatf("t2_got_ch%0d", i), got[i], 8);
      chk("t2_drops", drop_cnt, 0);

      // Test 3: no responses, ch1 streams 40 requests
      do_reset();
      n_iss = 0;
      first_key = '0;
      last_key = '0;
      for (int s = 0; s < 40; s++) begin
         ch_in_valid = 4'b0010;
         set_req(1, {80'h0, 8'h01, 8'(s)}, 4'(s));
         step();
         if (db_in_valid) begin
            if (n_iss == 0) first_key = db_in_key;
            last_key = db_in_key;
            n_iss++;
         end
      end
      ch_in_valid = '0;
      repeat (3) begin
         step();
         if (db_in_valid) n_iss++;
      end
      chk("t3_issued", n_iss, 16);
      chk("t3_first_key", first_key, 96'h100);
      chk("t3_last_key", last_key, 96'h10F);
      chk("t3_ready", ch_in_ready, 4'b1101);
      chk("t3_drop_ch1", drop_cnt[31:16], 16);
      chk("t3_drop_other", {drop_cnt[63:32], drop_cnt[15:0]}, 0);

      // Test 4: response arrives while outstanding is at the limit
      db_out_valid = 1'b1;
      db_out_flag  = 4'h9;
      step();
      db_out_valid = 1'b0;
      chk("t4_gate", db_in_valid, 0);
      chk("t4_route", ch_out_valid, 4'b0010);
      chk("t4_oflag", ch_out_flag, 4'h9);
      step();
      chk("t4_resume", db_in_valid, 1);
      chk("t4_resume_key", db_in_key, 96'h110);
      chk("t4_ready_back", ch_in_ready, 4'hF);
      step();
      chk("t4_full_again", db_in_valid, 0);

      // Test 5: spurious response after reset
      do_reset();
      chk("t5_err_clear", err_spurious, 0);
      db_out_valid = 1'b1;
      db_out_flag  = 4'h7;
      step();
      db_out_valid = 1'b0;
      chk("t5_err_set", err_spurious, 1);
      chk("t5_no_route", ch_out_valid, 0);
      repeat (3) step();
      chk("t5_err_sticky", err_spurious, 1);
      chk("t5_no_route_later", ch_out_valid, 0);

      // Test 6: asynchronous reset with 5 requests outstanding
      for (int s = 0; s < 6; s++) begin
         ch_in_valid = 4'b0001;
         set_req(0, {80'h0, 8'h00, 8'(s)}, 4'hA);
         step();
      end
      chk("t6_pre_valid", db_in_valid, 1);
      #3;
      sys_rst_n = 1'b0;
      #1;
      chk("t6_async_db_valid", db_in_valid, 0);
      chk("t6_async_key", db_in_key, 0);
      chk("t6_async_flag", db_in_flag, 0);
      chk("t6_async_ready", ch_in_ready, 4'hF);
      chk("t6_async_err", err_spurious, 0);
      chk("t6_async_out", ch_out_valid, 0);
      ch_in_valid = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      sys_rst_n = 1'b1;
      step();
      ch_in_valid = 4'b0011;
      set_req(0, {80'h0, 8'h00, 8'h20}, 4'h1);
      set_req(1, {80'h0, 8'h01, 8'h21}, 4'h2);
      step();
      ch_in_valid = '0;
      step();
      chk("t6_first_ch0", db_in_key, 96'h0020);
      step();
      chk("t6_second_ch1", db_in_key, 96'h0121);
      db_out_valid = 1'b1;
      db_out_flag  = 4'hC;
      step();
      chk("t6_route0", ch_out_valid, 4'b0001);
      step();
      chk("t6_route1", ch_out_valid, 4'b0010);
      chk("t6_err_still_clear", err_spurious, 0);
      step();
      db_out_valid = 1'b0;
      chk("t6_late_err", err_spurious, 1);
      chk("t6_late_no_route", ch_out_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
